// File: rtl/scan_hex_formatter.sv
// Buffers PS/2 scan-code bytes and prints each as "HH<sep>" over the UART write port.
// Optional `CRLF_EN inserts CR/LF after every BYTES_PER_LINE bytes.
module scan_hex_formatter #(
    parameter int          FIFO_AW        = 2,
    parameter int          BYTES_PER_LINE = 8,
    parameter logic [7:0]  SEP_CHAR       = 8'h20,
    parameter bit          LOWERCASE      = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_data,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       drop_tick,
    output logic [7:0] drop_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        SEP
`ifdef CRLF_EN
        ,
        CR,
        LF
`endif
    } state_t;

    state_t           state_q;
    logic [7:0]       byte_q;
    logic             wr_uart_q;
    logic [7:0]       w_data_q;
    logic             drop_tick_q;
    logic [7:0]       drop_count_q;
    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wptr_q, rptr_q;
    logic             fifo_empty, fifo_full, push, pop;

`ifdef CRLF_EN
    localparam logic [7:0] BPL = 8'(BYTES_PER_LINE);
    logic [7:0] line_cnt_q;
`endif

    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        // 'a'-10 = 8'h57, 'A'-10 = 8'h37
        return (LOWERCASE ? 8'h57 : 8'h37) + {4'h0, n};
    endfunction

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                        (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    // Full is judged before this cycle's pop, so a same-cycle pop never admits a write.
    assign push = scan_done_tick && !fifo_full;
    assign pop  = (state_q == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wptr_q[FIFO_AW-1:0]] <= scan_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            drop_tick_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            if (push)
                wptr_q <= wptr_q + 1'b1;
            if (pop)
                rptr_q <= rptr_q + 1'b1;
            drop_tick_q <= scan_done_tick && fifo_full;
            if (scan_done_tick && fifo_full && drop_count_q != 8'hFF)
                drop_count_q <= drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            wr_uart_q <= 1'b0;
            w_data_q  <= '0;
`ifdef CRLF_EN
            line_cnt_q <= '0;
`endif
        end else begin
            wr_uart_q <= 1'b0;
            case (state_q)
                IDLE: if (!fifo_empty) begin
                    byte_q  <= mem_q[rptr_q[FIFO_AW-1:0]];
                    state_q <= HI;
                end
                HI: if (!tx_full) begin
                    wr_uart_q <= 1'b1;
                    w_data_q  <= to_ascii(byte_q[7:4]);
                    state_q   <= LO;
                end
                LO: if (!tx_full) begin
                    wr_uart_q <= 1'b1;
                    w_data_q  <= to_ascii(byte_q[3:0]);
                    state_q   <= SEP;
                end
                SEP: if (!tx_full) begin
                    wr_uart_q <= 1'b1;
                    w_data_q  <= SEP_CHAR;
`ifdef CRLF_EN
                    if (line_cnt_q + 8'd1 == BPL) begin
                        line_cnt_q <= '0;
                        state_q    <= CR;
                    end else begin
                        line_cnt_q <= line_cnt_q + 8'd1;
                        state_q    <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
`ifdef CRLF_EN
                CR: if (!tx_full) begin
                    wr_uart_q <= 1'b1;
                    w_data_q  <= 8'h0D;
                    state_q   <= LF;
                end
                LF: if (!tx_full) begin
                    wr_uart_q <= 1'b1;
                    w_data_q  <= 8'h0A;
                    state_q   <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_uart    = wr_uart_q;
    assign w_data     = w_data_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign drop_tick  = drop_tick_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_scan_hex_formatter.sv
// Directed bench for scan_hex_formatter (BYTES_PER_LINE=2; CRLF checks follow `CRLF_EN).
module tb_scan_hex_formatter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_done_tick = 1'b0;
    logic [7:0] scan_data = 8'h00;
    logic       tx_full = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       busy;
    logic       drop_tick;
    logic [7:0] drop_count;

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int drops    = 0;
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    scan_hex_formatter #(
        .FIFO_AW(2),
        .BYTES_PER_LINE(2),
        .SEP_CHAR(8'h20),
        .LOWERCASE(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .scan_done_tick(scan_done_tick),
        .scan_data(scan_data),
        .tx_full(tx_full),
        .wr_uart(wr_uart),
        .w_data(w_data),
        .busy(busy),
        .drop_tick(drop_tick),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_uart) begin
                got.push_back(w_data);
                got_cyc.push_back(cyc);
            end
            if (drop_tick)
                drops++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        scan_done_tick = 1'b0;
        tx_full = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        got.delete();
        got_cyc.delete();
        drops = 0;
    endtask

    task automatic send(input logic [7:0] b, output int edge_idx);
        @(negedge clk);
        scan_done_tick = 1'b1;
        scan_data = b;
        edge_idx = cyc + 1;
        @(negedge clk);
        scan_done_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        compared++; if (wr_uart !== 1'b0) begin failed++; $display("FAIL reset_wr got %b exp 0", wr_uart); end
        compared++; if (w_data !== 8'h00) begin failed++; $display("FAIL reset_wdata got %h exp 00", w_data); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        compared++; if (drop_tick !== 1'b0) begin failed++; $display("FAIL reset_droptick got %b exp 0", drop_tick); end
        compared++; if (drop_count !== 8'h00) begin failed++; $display("FAIL reset_dropcnt got %h exp 00", drop_count); end
        do_reset();
    endtask

    task automatic test_single();
        int e;
        do_reset();
        send(8'h1C, e);
        wait_idle(50);
        exp_q = '{8'h31, 8'h43, 8'h20};
        compared++; if (got.size() != 3) begin failed++; $display("FAIL single_len got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failed++; $display("FAIL single_char%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
            compared++;
            if (i >= got_cyc.size() || got_cyc[i] != e + 2 + i) begin
                failed++; $display("FAIL single_cyc%0d got %0d exp %0d", i, (i < got_cyc.size()) ? got_cyc[i] : -1, e + 2 + i);
            end
        end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL single_busy got %b exp 0", busy); end
    endtask

    task automatic test_burst();
        do_reset();
        @(negedge clk);
        scan_done_tick = 1'b1; scan_data = 8'hE0;
        @(negedge clk); scan_data = 8'hF0;
        @(negedge clk); scan_data = 8'h75;
        @(negedge clk); scan_done_tick = 1'b0;
        wait_idle(100);
`ifdef CRLF_EN
        exp_q = '{8'h45, 8'h30, 8'h20, 8'h46, 8'h30, 8'h20, 8'h0D, 8'h0A, 8'h37, 8'h35, 8'h20};
`else
        exp_q = '{8'h45, 8'h30, 8'h20, 8'h46, 8'h30, 8'h20, 8'h37, 8'h35, 8'h20};
`endif
        compared++; if (got.size() != exp_q.size()) begin failed++; $display("FAIL burst_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failed++; $display("FAIL burst_char%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        compared++; if (drops != 0) begin failed++; $display("FAIL burst_drops got %0d exp 0", drops); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL burst_busy got %b exp 0", busy); end
    endtask

    task automatic test_overflow();
        int e;
        logic [7:0] vals [6];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        do_reset();
        tx_full = 1'b1;
        send(8'hA5, e);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            scan_done_tick = 1'b1;
            scan_data = vals[i];
            @(negedge clk);
        end
        scan_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (drops != 2) begin failed++; $display("FAIL ovf_droptick got %0d exp 2", drops); end
        compared++; if (drop_count !== 8'd2) begin failed++; $display("FAIL ovf_dropcnt got %0d exp 2", drop_count); end
        compared++; if (got.size() != 0) begin failed++; $display("FAIL ovf_stalled got %0d chars exp 0", got.size()); end
        compared++; if (busy !== 1'b1) begin failed++; $display("FAIL ovf_busy got %b exp 1", busy); end
        tx_full = 1'b0;
        wait_idle(200);
`ifdef CRLF_EN
        exp_q = '{8'h41, 8'h35, 8'h20, 8'h31, 8'h31, 8'h20, 8'h0D, 8'h0A,
                  8'h32, 8'h32, 8'h20, 8'h33, 8'h33, 8'h20, 8'h0D, 8'h0A, 8'h34, 8'h34, 8'h20};
`else
        exp_q = '{8'h41, 8'h35, 8'h20, 8'h31, 8'h31, 8'h20, 8'h32, 8'h32, 8'h20,
                  8'h33, 8'h33, 8'h20, 8'h34, 8'h34, 8'h20};
`endif
        compared++; if (got.size() != exp_q.size()) begin failed++; $display("FAIL ovf_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failed++; $display("FAIL ovf_char%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall_lo();
        int e;
        int k;
        do_reset();
        send(8'h1C, e);
        k = 0;
        while (!wr_uart && k < 20) begin
            @(negedge clk);
            k++;
        end
        compared++; if (wr_uart !== 1'b1) begin failed++; $display("FAIL stall_first got wr=%b exp 1", wr_uart); end
        tx_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (wr_uart !== 1'b0) begin failed++; $display("FAIL stall_wr%0d got %b exp 0", i, wr_uart); end
        end
        tx_full = 1'b0;
        wait_idle(50);
        exp_q = '{8'h31, 8'h43, 8'h20};
        compared++; if (got.size() != 3) begin failed++; $display("FAIL stall_len got %0d exp 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failed++; $display("FAIL stall_char%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_line_break();
        int e;
        do_reset();
        send(8'h1C, e);
        send(8'h32, e);
        send(8'h45, e);
        wait_idle(100);
`ifdef CRLF_EN
        exp_q = '{8'h31, 8'h43, 8'h20, 8'h33, 8'h32, 8'h20, 8'h0D, 8'h0A, 8'h34, 8'h35, 8'h20};
`else
        exp_q = '{8'h31, 8'h43, 8'h20, 8'h33, 8'h32, 8'h20, 8'h34, 8'h35, 8'h20};
`endif
        compared++; if (got.size() != exp_q.size()) begin failed++; $display("FAIL line_len got %0d exp %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failed++; $display("FAIL line_char%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        @(negedge clk);
        scan_done_tick = 1'b1; scan_data = 8'h1C;
        @(negedge clk); scan_data = 8'h32;
        @(negedge clk); scan_data = 8'h45;
        @(negedge clk); scan_done_tick = 1'b0;
        k = 0;
        while (!wr_uart && k < 20) begin
            @(negedge clk);
            k++;
        end
        compared++; if (wr_uart !== 1'b1) begin failed++; $display("FAIL rmid_first got wr=%b exp 1", wr_uart); end
        reset = 1'b1;
        #1;
        compared++; if (wr_uart !== 1'b0) begin failed++; $display("FAIL rmid_wr got %b exp 0", wr_uart); end
        compared++; if (w_data !== 8'h00) begin failed++; $display("FAIL rmid_wdata got %h exp 00", w_data); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_busy got %b exp 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        got.delete();
        got_cyc.delete();
        repeat (20) @(negedge clk);
        compared++; if (got.size() != 0) begin failed++; $display("FAIL rmid_after got %0d chars exp 0", got.size()); end
        compared++; if (busy !== 1'b0) begin failed++; $display("FAIL rmid_idle got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_stall_lo();
        test_line_break();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
